// File: rtl/module_decod_ctrl.sv
// SECDED (8,4) decoder with a four-state handshake FSM and saturating error-event counters.
// A word is captured in IDLE, its syndrome is registered in CHECK, the result in CORRECT,
// and the result is presented in DONE.
module module_decod_ctrl #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_word,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [3:0]       out_data,
    output logic [7:0]       out_word,
    output logic             err_single,
    output logic             err_double,
    output logic [2:0]       err_pos,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_single,
    output logic [CNT_W-1:0] cnt_double,
    output logic             busy
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCheck   = 2'd1;
    localparam logic [1:0] StCorrect = 2'd2;
    localparam logic [1:0] StDone    = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [7:0]       word_q;
    logic [2:0]       syn_q, syn_d;
    logic             par_q, par_d;
    logic [7:0]       fix_word;
    logic             is_single, is_double;
    logic [7:0]       out_word_q;
    logic [3:0]       out_data_q;
    logic             err_single_q, err_double_q;
    logic [2:0]       err_pos_q;
    logic [CNT_W-1:0] cnt_single_q, cnt_double_q;

    // Bit i of the codeword is Hamming position i+1; bit 7 is the overall parity bit.
    always_comb begin
        syn_d[0] = word_q[0] ^ word_q[2] ^ word_q[4] ^ word_q[6];
        syn_d[1] = word_q[1] ^ word_q[2] ^ word_q[5] ^ word_q[6];
        syn_d[2] = word_q[3] ^ word_q[4] ^ word_q[5] ^ word_q[6];
        par_d    = ^word_q;
    end

    always_comb begin
        fix_word  = word_q;
        is_single = par_q;
        is_double = !par_q && (syn_q != 3'd0);
        if (par_q) begin
            if (syn_q == 3'd0) begin
                fix_word[7] = ~word_q[7];
            end else begin
                for (int i = 0; i < 7; i++) begin
                    if (syn_q == 3'(i + 1)) fix_word[i] = ~word_q[i];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (in_valid) state_d = StCheck;
            StCheck:   state_d = StCorrect;
            StCorrect: state_d = StDone;
            StDone:    if (out_ready) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            word_q       <= 8'd0;
            syn_q        <= 3'd0;
            par_q        <= 1'b0;
            out_word_q   <= 8'd0;
            out_data_q   <= 4'd0;
            err_single_q <= 1'b0;
            err_double_q <= 1'b0;
            err_pos_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && in_valid) word_q <= in_word;
            if (state_q == StCheck) begin
                syn_q <= syn_d;
                par_q <= par_d;
            end
            if (state_q == StCorrect) begin
                out_word_q   <= fix_word;
                out_data_q   <= {fix_word[6], fix_word[5], fix_word[4], fix_word[2]};
                err_single_q <= is_single;
                err_double_q <= is_double;
                err_pos_q    <= syn_q;
            end
        end
    end

    // Clear wins over an increment landing on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_single_q <= '0;
            cnt_double_q <= '0;
        end else if (clr_cnt) begin
            cnt_single_q <= '0;
            cnt_double_q <= '0;
        end else if (state_q == StCorrect) begin
            if (is_single && cnt_single_q != {CNT_W{1'b1}}) cnt_single_q <= cnt_single_q + 1'b1;
            if (is_double && cnt_double_q != {CNT_W{1'b1}}) cnt_double_q <= cnt_double_q + 1'b1;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StDone);
    assign busy       = (state_q != StIdle);
    assign out_word   = out_word_q;
    assign out_data   = out_data_q;
    assign err_single = err_single_q;
    assign err_double = err_double_q;
    assign err_pos    = err_pos_q;
    assign cnt_single = cnt_single_q;
    assign cnt_double = cnt_double_q;

endmodule
